uart_rx_core: RTL and testbench
===============================

Name: uart_rx_core

Overview:
- Receive serial engine of the UART; sits between the RX pad and the RX FIFO/register stage that serves RXDATA and RXSTATUS.
- Synchronises the rx line, detects and validates start bits, and mid-bit samples 8 data bits, optional parity and one stop bit.
- Presents each byte on a valid/ready interface to the FIFO, with per-frame parity, framing and overrun flags for the RXIrqFlags_t status bits.

Parameters:
- DATA_W, 8, data bits per frame (LSB first).
- DIV_W, 16, width of the bit-period divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_i  in  1  raw serial line, idle high.
- rx_en_i  in  1  receiver enable (mode/master decode done upstream).
- divider_i  in  DIV_W  clocks per bit; values below 4 are treated as 4.
- parity_en_i  in  1  parity bit present.
- parity_odd_i  in  1  1 = odd parity, 0 = even parity.
- flush_i  in  1  Config_t.flush_rx; aborts the frame and drops the held byte.
- data_o  out  DATA_W  received byte.
- valid_o  out  1  byte available.
- ready_i  in  1  FIFO accepts the byte.
- parity_err_o  out  1  one-cycle pulse: parity mismatch.
- framing_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overrun_err_o  out  1  one-cycle pulse: frame completed while valid_o was still held.
- busy_o  out  1  state != RX_IDLE.

Behaviour:
- Reset: all outputs 0; state RX_IDLE; synchroniser flops set to 1.
- rx_i passes through a 2-flop synchroniser, giving 2 cycles of latency to rxs.
- RX_IDLE:
  - A falling edge on rxs loads the bit counter with 0 and starts the cycle counter.
  - At cycle floor(div/2): if rxs is still 0, go to RX_SHIFT with the cycle counter reset; otherwise it is a false start and the block stays idle, with no flags raised.
- Sample point: every div cycles after start validation, i.e. mid-bit.
- RX_SHIFT:
  - Each sample shifts into the MSB of the shift register (LSB-first reception).
  - After DATA_W samples, go to RX_PARITY if parity_en_i, else RX_STOP.
- RX_PARITY:
  - Sample, then compare against the XOR of the data bits, plus 1 if odd parity.
  - Latch a mismatch; go to RX_STOP.
- RX_STOP: sample, then return to RX_IDLE. The next start edge is accepted from the following cycle.
- Frame commit on the stop sample cycle:
  - If valid_o = 0: data_o is loaded and valid_o is set on the next cycle.
  - If valid_o = 1 and ready_i = 0: the new byte is discarded, the old byte is kept and overrun_err_o pulses.
  - If valid_o = 1 and ready_i = 1 in the same cycle: this is a hand-off, not an overrun; the new byte replaces the old one and valid_o stays 1.
  - parity_err_o and framing_err_o pulse in the cycle after the stop sample, regardless of overrun.
  - A byte with a framing error is still delivered.
- Handshake: valid_o drops the cycle after valid_o && ready_i. data_o is stable while valid_o = 1.
- divider_i is latched at start validation; changes mid-frame take effect on the next frame.
- rx_en_i = 0 or flush_i = 1:
  - Either one forces RX_IDLE and clears the counters.
  - flush_i also clears valid_o.
  - rx_en_i = 0 keeps any pending byte.
  - No error pulses are generated by either.
- A line held low (break) produces a framing error. The block then waits in RX_IDLE for rxs = 1 before arming edge detection again.

Optional Feature:
- UART_RX_MAJORITY_EN defined:
  - Each sample is the 2-of-3 majority of rxs at cycles mid-1, mid and mid+1.
  - Start validation also uses the majority.
  - The commit point moves one cycle later.
- Undefined: a single sample at mid-bit.

Decomposition:
- uart_defs package holds:
  - RXState_t (RX_IDLE/RX_SHIFT/RX_PARITY/RX_STOP), reused as-is.
  - RXIrqFlags_t for the downstream status register.
  - New constant RX_MIN_DIVIDER = 4.
- One natural sub-module, uart_rx_sync: the 2-flop synchroniser with falling-edge detect. It is reused by CTS input handling in flow control.

Test Plan:
- div=16, 8N1, send 0xA5 with ready_i = 1 → data_o = 0xA5, valid_o held 1 cycle; no error pulses.
- div=16, parity even, send 0x03 with parity bit 1 → parity_err_o pulses once; data_o = 0x03 still delivered.
- div=8, send 0x5A with the stop bit driven 0 → framing_err_o pulse; after a 2-bit-time break, the next frame 0x11 is received correctly.
- ready_i = 0, send 0x12 then 0x34 → data_o stays 0x12; overrun_err_o pulses at the second stop bit. Raising ready_i gives exactly one transfer of 0x12.
- div=16, 4-cycle low glitch on idle line → no state change past RX_IDLE, valid_o stays 0. Repeat with a 1-cycle glitch mid-bit under UART_RX_MAJORITY_EN → byte unaffected.
- Assert flush_i mid-data-bit 3, then send 0xC3 → partial frame dropped; 0xC3 received cleanly. Assert rst mid-frame → all outputs 0 the same cycle.

Source files
------------

// File: rtl/uart_defs.sv
// Shared UART types and constants for the receive path and its status register.
package uart_defs;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_SHIFT,
    RX_PARITY,
    RX_STOP
  } RXState_t;

  // Per-frame error pulses feeding the downstream RX status/IRQ register.
  typedef struct packed {
    logic parity;
    logic framing;
    logic overrun;
  } RXIrqFlags_t;

  localparam int RX_MIN_DIVIDER = 4;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// Byte hand-off from the UART receive engine to the RX FIFO, with per-frame status pulses.
interface uart_rx_core_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_o;
    logic              valid_o;
    logic              ready_i;
    logic              parity_err_o;
    logic              framing_err_o;
    logic              overrun_err_o;

    modport master (
        output data_o, valid_o, parity_err_o, framing_err_o, overrun_err_o,
        input  ready_i
    );

    modport slave (
        input  data_o, valid_o, parity_err_o, framing_err_o, overrun_err_o,
        output ready_i
    );
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser with falling-edge detect; shared by the RX line and CTS input.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic fall
);
    logic meta, sync, prev;

    // Preset high so an idle-high line never produces a spurious edge out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            sync <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign dout = sync;
    assign fall = prev & ~sync;
endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start validation, mid-bit sampling, parity/stop checks, byte hand-off.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each mid-bit point.
module uart_rx_core
    import uart_defs::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_i,
    input  logic             rx_en_i,
    input  logic [DIV_W-1:0] divider_i,
    input  logic             parity_en_i,
    input  logic             parity_odd_i,
    input  logic             flush_i,
    output logic             busy_o,
    uart_rx_core_if.master   rx_bus
);
    localparam int CW = DIV_W + 1;
    localparam int BW = $clog2(DATA_W + 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] OFS = CW'(1);
`else
    localparam logic [CW-1:0] OFS = CW'(0);
`endif

    logic              rxs, fall, samp;
    RXState_t          state;
    logic [CW-1:0]     cnt, half_pt, samp_pt;
    logic [BW-1:0]     bit_cnt;
    logic [DIV_W-1:0]  div_eff, div_q;
    logic [DATA_W-1:0] sh, data;
    logic              valid, par_err_q, start_pend;
    RXIrqFlags_t       err;

    uart_rx_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (rx_i),
        .dout (rxs),
        .fall (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    // Keep two cycles of history so a decision at mid+1 can vote over mid-1..mid+1.
    logic rxs_d1, rxs_d2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxs_d1 <= 1'b1;
            rxs_d2 <= 1'b1;
        end else begin
            rxs_d1 <= rxs;
            rxs_d2 <= rxs_d1;
        end
    end
    assign samp = majority3(rxs, rxs_d1, rxs_d2);
`else
    assign samp = rxs;
`endif

    assign div_eff = (divider_i < DIV_W'(RX_MIN_DIVIDER)) ? DIV_W'(RX_MIN_DIVIDER) : divider_i;
    assign half_pt = CW'(div_eff >> 1) + OFS;
    assign samp_pt = CW'(div_q) + OFS;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            div_q      <= '0;
            sh         <= '0;
            data       <= '0;
            valid      <= 1'b0;
            par_err_q  <= 1'b0;
            start_pend <= 1'b0;
            err        <= '0;
        end else begin
            err <= '0;
            if (valid && rx_bus.ready_i)
                valid <= 1'b0;

            if (!rx_en_i || flush_i) begin
                state      <= RX_IDLE;
                cnt        <= '0;
                bit_cnt    <= '0;
                start_pend <= 1'b0;
                if (flush_i)
                    valid <= 1'b0;
            end else if (state == RX_IDLE) begin
                // A fall needs rxs high the cycle before, so a held break cannot re-arm.
                if (start_pend) begin
                    cnt <= cnt + 1'b1;
                    if (cnt == half_pt) begin
                        start_pend <= 1'b0;
                        if (!samp) begin
                            state     <= RX_SHIFT;
                            cnt       <= OFS + 1'b1;
                            div_q     <= div_eff;
                            bit_cnt   <= '0;
                            par_err_q <= 1'b0;
                        end
                    end
                end else if (fall) begin
                    start_pend <= 1'b1;
                    cnt        <= CW'(1);
                    bit_cnt    <= '0;
                end
            end else begin
                cnt <= cnt + 1'b1;
                if (cnt == samp_pt) begin
                    cnt <= OFS + 1'b1;
                    if (state == RX_SHIFT) begin
                        sh      <= {samp, sh[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BW'(DATA_W - 1))
                            state <= parity_en_i ? RX_PARITY : RX_STOP;
                    end else if (state == RX_PARITY) begin
                        par_err_q <= samp ^ (^sh) ^ parity_odd_i;
                        state     <= RX_STOP;
                    end else begin
                        // Stop sample: commit, unless a held byte is not being taken this cycle.
                        state       <= RX_IDLE;
                        err.parity  <= par_err_q;
                        err.framing <= ~samp;
                        if (!valid || rx_bus.ready_i) begin
                            data  <= sh;
                            valid <= 1'b1;
                        end else begin
                            err.overrun <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign busy_o               = (state != RX_IDLE);
    assign rx_bus.data_o        = data;
    assign rx_bus.valid_o       = valid;
    assign rx_bus.parity_err_o  = err.parity;
    assign rx_bus.framing_err_o = err.framing;
    assign rx_bus.overrun_err_o = err.overrun;
endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: table of single frames plus multi-cycle corner sequences.
module tb_uart_rx_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx = 1'b1;
    logic        rx_en = 1'b1;
    logic [15:0] divider = 16'd16;
    logic        par_en = 1'b0;
    logic        par_odd = 1'b0;
    logic        flush = 1'b0;
    logic        busy;

    uart_rx_core_if #(.DATA_W(8)) bus();

    uart_rx_core #(.DATA_W(8), .DIV_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (rx),
        .rx_en_i      (rx_en),
        .divider_i    (divider),
        .parity_en_i  (par_en),
        .parity_odd_i (par_odd),
        .flush_i      (flush),
        .busy_o       (busy),
        .rx_bus       (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int n_xfer = 0, n_vcyc = 0, n_par = 0, n_frm = 0, n_ovr = 0, n_busy = 0;
    int b_xfer, b_vcyc, b_par, b_frm, b_ovr, b_busy;
    logic [7:0] last_data = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.valid_o && bus.ready_i) begin
                n_xfer++;
                last_data = bus.data_o;
            end
            if (bus.valid_o)       n_vcyc++;
            if (bus.parity_err_o)  n_par++;
            if (bus.framing_err_o) n_frm++;
            if (bus.overrun_err_o) n_ovr++;
            if (busy)              n_busy++;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        b_xfer = n_xfer; b_vcyc = n_vcyc; b_par = n_par;
        b_frm = n_frm; b_ovr = n_ovr; b_busy = n_busy;
    endtask

    // Drives start, data LSB first, optional parity and the stop level; stop is left on the line.
    task automatic send_frame(input logic [7:0] d, input int div, input logic pen,
                              input logic pbit, input logic stopv, input int gbit);
        rx = 1'b0;
        tick(div);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == gbit) begin
                tick(div / 2);
                rx = ~d[i];
                tick(1);
                rx = d[i];
                tick(div - div / 2 - 1);
            end else begin
                tick(div);
            end
        end
        if (pen) begin
            rx = pbit;
            tick(div);
        end
        rx = stopv;
        tick(div);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        tick(n);
    endtask

    typedef struct {
        int         cfg_div;
        int         line_div;
        logic       pen;
        logic       podd;
        logic [7:0] data;
        logic       pbit;
        logic       stopv;
        int         exp_par;
        int         exp_frm;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16, 16, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 0, 0};
        vecs[1] = '{16, 16, 1'b1, 1'b0, 8'h03, 1'b1, 1'b1, 1, 0};
        vecs[2] = '{16, 16, 1'b1, 1'b0, 8'h07, 1'b1, 1'b1, 0, 0};
        vecs[3] = '{16, 16, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 0, 0};
        vecs[4] = '{16, 16, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b1, 1, 0};
        vecs[5] = '{ 8,  8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 0, 1};
        vecs[6] = '{ 2,  4, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 0, 0};
        vecs[7] = '{11, 11, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 0, 0};
        vecs[8] = '{16, 16, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 0};

        bus.ready_i = 1'b1;
        #3;
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_data", int'(bus.data_o), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_errs", int'({bus.parity_err_o, bus.framing_err_o, bus.overrun_err_o}), 0);
        tick(3);
        rst = 1'b0;
        tick(5);
        chk("post_rst_valid", int'(bus.valid_o), 0);
        chk("post_rst_busy", int'(busy), 0);

        foreach (vecs[k]) begin
            divider = 16'(vecs[k].cfg_div);
            par_en  = vecs[k].pen;
            par_odd = vecs[k].podd;
            snap();
            send_frame(vecs[k].data, vecs[k].line_div, vecs[k].pen, vecs[k].pbit, vecs[k].stopv, -1);
            idle(3 * vecs[k].line_div + 20);
            chk($sformatf("v%0d_xfer", k), n_xfer - b_xfer, 1);
            chk($sformatf("v%0d_data", k), int'(last_data), int'(vecs[k].data));
            chk($sformatf("v%0d_vcyc", k), n_vcyc - b_vcyc, 1);
            chk($sformatf("v%0d_par", k), n_par - b_par, vecs[k].exp_par);
            chk($sformatf("v%0d_frm", k), n_frm - b_frm, vecs[k].exp_frm);
            chk($sformatf("v%0d_ovr", k), n_ovr - b_ovr, 0);
        end
        par_en = 1'b0;

        // Framing error followed by a 2-bit break, then a clean frame.
        divider = 16'd8;
        snap();
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, -1);
        tick(16);
        chk("break_busy", int'(busy), 0);
        idle(20);
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1);
        idle(40);
        chk("break_frm", n_frm - b_frm, 1);
        chk("break_xfer", n_xfer - b_xfer, 2);
        chk("break_next_data", int'(last_data), 'h11);

        // Overrun: second byte lost while first is held.
        divider = 16'd16;
        bus.ready_i = 1'b0;
        snap();
        send_frame(8'h12, 16, 1'b0, 1'b0, 1'b1, -1);
        send_frame(8'h34, 16, 1'b0, 1'b0, 1'b1, -1);
        idle(40);
        chk("ovr_data", int'(bus.data_o), 'h12);
        chk("ovr_valid", int'(bus.valid_o), 1);
        chk("ovr_pulse", n_ovr - b_ovr, 1);
        chk("ovr_frm", n_frm - b_frm, 0);
        bus.ready_i = 1'b1;
        tick(6);
        chk("ovr_xfer", n_xfer - b_xfer, 1);
        chk("ovr_xfer_data", int'(last_data), 'h12);
        chk("ovr_valid_drop", int'(bus.valid_o), 0);

        // Short glitch on an idle line is a false start.
        snap();
        rx = 1'b0;
        tick(4);
        idle(60);
        chk("glitch_busy", n_busy - b_busy, 0);
        chk("glitch_vcyc", n_vcyc - b_vcyc, 0);

`ifdef UART_RX_MAJORITY_EN
        snap();
        send_frame(8'h96, 16, 1'b0, 1'b0, 1'b1, 2);
        idle(60);
        chk("maj_xfer", n_xfer - b_xfer, 1);
        chk("maj_data", int'(last_data), 'h96);
`endif

        // Flush mid data bit 3 drops both the partial frame and the held byte.
        bus.ready_i = 1'b0;
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b1, -1);
        idle(40);
        chk("flush_pre_valid", int'(bus.valid_o), 1);
        rx = 1'b0;
        tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b1; tick(16);
        rx = 1'b0; tick(16);
        rx = 1'b0; tick(8);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        rx = 1'b1;
        chk("flush_valid", int'(bus.valid_o), 0);
        chk("flush_busy", int'(busy), 0);
        idle(200);
        bus.ready_i = 1'b1;
        snap();
        send_frame(8'hC3, 16, 1'b0, 1'b0, 1'b1, -1);
        idle(60);
        chk("flush_next_xfer", n_xfer - b_xfer, 1);
        chk("flush_next_data", int'(last_data), 'hC3);
        chk("flush_next_errs", (n_par - b_par) + (n_frm - b_frm) + (n_ovr - b_ovr), 0);

        // Disable mid-frame keeps the held byte; reset mid-frame clears everything at once.
        bus.ready_i = 1'b0;
        send_frame(8'h7E, 16, 1'b0, 1'b0, 1'b1, -1);
        idle(40);
        rx = 1'b0;
        tick(40);
        chk("en_busy_mid", int'(busy), 1);
        rx_en = 1'b0;
        tick(1);
        chk("en_busy_off", int'(busy), 0);
        chk("en_keep_valid", int'(bus.valid_o), 1);
        chk("en_keep_data", int'(bus.data_o), 'h7E);
        idle(40);
        rx_en = 1'b1;
        rx = 1'b0;
        tick(30);
        chk("rst_mid_busy_pre", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", int'(bus.valid_o), 0);
        chk("rst_mid_data", int'(bus.data_o), 0);
        chk("rst_mid_busy", int'(busy), 0);
        tick(2);
        rx = 1'b1;
        rst = 1'b0;
        tick(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
